// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the branch predict unit.
//   bp_state_e      RUN / HALTED control state
//   cnt_weak_t/nt   weakly-taken / weakly-not-taken counter values for a given width
//   CNT_WEAK_T/NT   those values at the default 2-bit counter width
package bp_pkg;

    typedef enum logic {BP_RUN, BP_HALTED} bp_state_e;

    function automatic int cnt_weak_t(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int cnt_weak_nt(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    localparam int CNT_WEAK_T  = cnt_weak_t(2);
    localparam int CNT_WEAK_NT = cnt_weak_nt(2);

endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: next value of a saturating up/down counter.
//   cnt_i  current count
//   inc_i  1 = count up (saturate at all-ones), 0 = count down (saturate at zero)
//   cnt_o  next count
module bp_sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb cnt_o = inc_i ? (&cnt_i ? cnt_i : cnt_i + 1'b1) : (|cnt_i ? cnt_i - 1'b1 : cnt_i);

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with saturating counters, EX-stage resolve, redirect and halt.
//   F_PC -> F_PredTaken/F_PredTarget        combinational fetch-stage prediction
//   E_* , Imm, Branch, Jump, JalrSel, Halt, AluResult   EX-stage resolve inputs
//   PC_Imm, PC_Four, BrPC, PcSel, Flush     redirect outputs
//   Halted                                  latched halt state, left only by reset_n=0
//   Perf_Branches/Perf_Mispredicts          counters when BP_PERF_CNT_EN is defined, else 0
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int IDX_W = 4,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [PC_W-1:0] F_PC,
    output logic            F_PredTaken,
    output logic [31:0]     F_PredTarget,
    input  logic            E_Valid,
    input  logic [PC_W-1:0] E_PC,
    input  logic            E_PredTaken,
    input  logic [31:0]     E_PredTarget,
    input  logic [31:0]     Imm,
    input  logic            Branch,
    input  logic            Jump,
    input  logic            JalrSel,
    input  logic            Halt,
    input  logic [31:0]     AluResult,
    output logic [31:0]     PC_Imm,
    output logic [31:0]     PC_Four,
    output logic [31:0]     BrPC,
    output logic            PcSel,
    output logic            Flush,
    output logic            Halted,
    output logic [31:0]     Perf_Branches,
    output logic [31:0]     Perf_Mispredicts
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(cnt_weak_t(CNT_W));
    localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(cnt_weak_nt(CNT_W));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        logic [CNT_W-1:0] cnt;
    } btb_entry_t;

    btb_entry_t btb_q [DEPTH];
    bp_state_e  state_q, state_d;
    logic [PC_W-1:0] halt_pc_q, halt_pc_d;

    btb_entry_t f_ent, e_ent;
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic f_hit, e_hit, taken, mispredict, upd;
    logic [CNT_W-1:0] cnt_nxt;
    logic unused_pc_lsb;

    assign unused_pc_lsb = &{1'b0, F_PC[1:0]};

    assign f_ent        = btb_q[F_PC[IDX_W+1:2]];
    assign f_hit        = f_ent.valid && f_ent.tag == F_PC[PC_W-1:IDX_W+2];
    assign F_PredTaken  = f_hit && f_ent.cnt[CNT_W-1];
    assign F_PredTarget = f_hit ? 32'(f_ent.target) : 32'd0;

    assign e_idx   = E_PC[IDX_W+1:2];
    assign e_tag   = E_PC[PC_W-1:IDX_W+2];
    assign e_ent   = btb_q[e_idx];
    assign e_hit   = e_ent.valid && e_ent.tag == e_tag;

    assign PC_Imm     = JalrSel ? AluResult : 32'(E_PC) + Imm;
    assign PC_Four    = 32'(E_PC) + 32'd4;
    assign taken      = Jump | (Branch & AluResult[0]);
    assign mispredict = (taken != E_PredTaken) | (taken & E_PredTaken & (E_PredTarget != PC_Imm));

    bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .cnt_i (e_ent.cnt),
        .inc_i (taken),
        .cnt_o (cnt_nxt)
    );

    // Halt (latched or new) outranks any branch redirect; reset silences everything.
    always_comb begin
        state_d   = state_q;
        halt_pc_d = halt_pc_q;
        PcSel     = 1'b0;
        Flush     = 1'b0;
        BrPC      = 32'd0;
        Halted    = 1'b0;
        upd       = 1'b0;
        if (reset_n) begin
            if (state_q == BP_HALTED) begin
                PcSel  = 1'b1;
                BrPC   = 32'(halt_pc_q);
                Halted = 1'b1;
            end else if (E_Valid && Halt) begin
                PcSel     = 1'b1;
                BrPC      = 32'(E_PC);
                state_d   = BP_HALTED;
                halt_pc_d = E_PC;
            end else if (E_Valid) begin
                Flush = mispredict;
                PcSel = mispredict;
                BrPC  = mispredict ? (taken ? PC_Imm : PC_Four) : 32'd0;
                upd   = Branch | Jump;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= BP_RUN;
            halt_pc_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WEAK_NT};
        end else begin
            state_q   <= state_d;
            halt_pc_q <= halt_pc_d;
            if (upd) begin
                if (e_hit) begin
                    btb_q[e_idx].cnt <= cnt_nxt;
                    if (taken)
                        btb_q[e_idx].target <= PC_Imm[PC_W-1:0];
                end else if (taken) begin
                    btb_q[e_idx] <= '{valid: 1'b1, tag: e_tag, target: PC_Imm[PC_W-1:0], cnt: WEAK_T};
                end
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_br_q, perf_mp_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            if (upd && !(&perf_br_q))
                perf_br_q <= perf_br_q + 32'd1;
            if (Flush && !(&perf_mp_q))
                perf_mp_q <= perf_mp_q + 32'd1;
        end
    end

    assign Perf_Branches    = perf_br_q;
    assign Perf_Mispredicts = perf_mp_q;
`else
    assign Perf_Branches    = 32'd0;
    assign Perf_Mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed vectors with a queue-based scoreboard for branch_predict_unit.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  F_PC = '0, E_PC = '0;
    logic        F_PredTaken, PcSel, Flush, Halted;
    logic [31:0] F_PredTarget, PC_Imm, PC_Four, BrPC, Perf_Branches, Perf_Mispredicts;
    logic        E_Valid = 0, E_PredTaken = 0, Branch = 0, Jump = 0, JalrSel = 0, Halt = 0;
    logic [31:0] E_PredTarget = '0, Imm = '0, AluResult = '0;

    branch_predict_unit dut (
        .clk(clk), .reset_n(reset_n), .F_PC(F_PC),
        .F_PredTaken(F_PredTaken), .F_PredTarget(F_PredTarget),
        .E_Valid(E_Valid), .E_PC(E_PC), .E_PredTaken(E_PredTaken), .E_PredTarget(E_PredTarget),
        .Imm(Imm), .Branch(Branch), .Jump(Jump), .JalrSel(JalrSel), .Halt(Halt),
        .AluResult(AluResult), .PC_Imm(PC_Imm), .PC_Four(PC_Four), .BrPC(BrPC),
        .PcSel(PcSel), .Flush(Flush), .Halted(Halted),
        .Perf_Branches(Perf_Branches), .Perf_Mispredicts(Perf_Mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        bit          pt;
        logic [31:0] tgt;
        bit          ps;
        bit          fl;
        logic [31:0] br;
        bit          brchk;
        bit          h;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (F_PredTaken !== e.pt || F_PredTarget !== e.tgt || PcSel !== e.ps ||
                Flush !== e.fl || Halted !== e.h || (e.brchk && BrPC !== e.br)) begin
                n_bad++;
                $display("FAIL %s: got pt=%b tgt=%h ps=%b fl=%b br=%h h=%b, want pt=%b tgt=%h ps=%b fl=%b br=%h(chk=%b) h=%b",
                         e.nm, F_PredTaken, F_PredTarget, PcSel, Flush, BrPC, Halted,
                         e.pt, e.tgt, e.ps, e.fl, e.br, e.brchk, e.h);
            end
        end
    end

    task automatic drv(input logic [8:0] fpc, input logic ev, input logic [8:0] epc,
                       input logic eptk, input logic [31:0] eptg, input logic [31:0] imm,
                       input logic b, input logic j, input logic jr, input logic hlt,
                       input logic [31:0] alu);
        F_PC = fpc; E_Valid = ev; E_PC = epc; E_PredTaken = eptk; E_PredTarget = eptg;
        Imm = imm; Branch = b; Jump = j; JalrSel = jr; Halt = hlt; AluResult = alu;
    endtask

    task automatic chk(input string nm, input bit pt, input logic [31:0] tgt, input bit ps,
                       input bit fl, input logic [31:0] br, input bit brchk, input bit h);
        exp_t e;
        e = '{nm, pt, tgt, ps, fl, br, brchk, h};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [8:0] fpc);
        drv(fpc, 0, 9'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        // reset: taken branch and halt request must be suppressed
        drv(9'h040, 1, 9'h080, 0, 0, 32'h20, 1, 0, 0, 1, 32'h1);
        chk("rst_quiet", 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        idle(9'h040); chk("post_rst_040", 0, 0, 0, 0, 0, 1, 0);
        idle(9'h080); chk("rst_no_alloc", 0, 0, 0, 0, 0, 1, 0);

        drv(9'h040, 1, 9'h040, 0, 0, 32'h20, 1, 0, 0, 0, 32'h1);
        chk("beq_taken", 0, 0, 1, 1, 32'h060, 1, 0);
        idle(9'h040); chk("beq_alloc", 1, 32'h060, 0, 0, 0, 1, 0);
        drv(9'h040, 1, 9'h040, 1, 32'h060, 32'h20, 1, 0, 0, 0, 32'h0);
        chk("beq_nt1", 1, 32'h060, 1, 1, 32'h044, 1, 0);
        drv(9'h040, 1, 9'h040, 0, 0, 32'h20, 1, 0, 0, 0, 32'h0);
        chk("beq_nt2", 0, 32'h060, 0, 0, 0, 1, 0);
        idle(9'h040); chk("beq_cnt0", 0, 32'h060, 0, 0, 0, 1, 0);

        drv(9'h010, 1, 9'h010, 0, 0, 0, 0, 1, 1, 0, 32'h0A4);
        chk("jalr_alloc", 0, 0, 1, 1, 32'h0A4, 1, 0);
        idle(9'h010); chk("jalr_a4", 1, 32'h0A4, 0, 0, 0, 1, 0);
        drv(9'h010, 1, 9'h010, 1, 32'h0A4, 0, 0, 1, 1, 0, 32'h0A8);
        chk("jalr_tgt_miss", 1, 32'h0A4, 1, 1, 32'h0A8, 1, 0);
        idle(9'h010); chk("jalr_a8", 1, 32'h0A8, 0, 0, 0, 1, 0);
        drv(9'h010, 1, 9'h010, 1, 32'h0A8, 0, 0, 1, 1, 0, 32'h0A8);
        chk("jalr_ok", 1, 32'h0A8, 0, 0, 0, 1, 0);

        drv(9'h040, 1, 9'h0C0, 0, 0, 32'h10, 1, 0, 0, 0, 32'h1);
        chk("alias_res", 0, 32'h060, 1, 1, 32'h0D0, 1, 0);
        idle(9'h040); chk("alias_miss", 0, 0, 0, 0, 0, 1, 0);
        idle(9'h0C0); chk("alias_new", 1, 32'h0D0, 0, 0, 0, 1, 0);

        drv(9'h104, 1, 9'h104, 1, 32'h0FC, 32'hFFFF_FFF8, 1, 0, 0, 0, 32'h1);
        chk("neg_imm", 0, 0, 0, 0, 0, 1, 0);
        drv(9'h104, 1, 9'h104, 1, 32'h0FC, 32'hFFFF_FFF8, 1, 0, 0, 0, 32'h1);
        chk("sat_up1", 1, 32'h0FC, 0, 0, 0, 1, 0);
        drv(9'h104, 1, 9'h104, 1, 32'h0FC, 32'hFFFF_FFF8, 1, 0, 0, 0, 32'h1);
        chk("sat_up2", 1, 32'h0FC, 0, 0, 0, 1, 0);
        drv(9'h104, 1, 9'h104, 1, 32'h0FC, 32'hFFFF_FFF8, 1, 0, 0, 0, 32'h0);
        chk("sat_dn", 1, 32'h0FC, 1, 1, 32'h108, 1, 0);
        idle(9'h104); chk("sat_hold", 1, 32'h0FC, 0, 0, 0, 1, 0);

        drv(9'h104, 1, 9'h1FC, 0, 0, 32'h20, 1, 0, 0, 1, 32'h1);
        chk("halt_req", 1, 32'h0FC, 1, 0, 32'h1FC, 1, 0);
        idle(9'h104); chk("halted", 1, 32'h0FC, 1, 0, 32'h1FC, 1, 1);
        drv(9'h104, 1, 9'h104, 1, 32'h0FC, 32'hFFFF_FFF8, 1, 0, 0, 0, 32'h0);
        chk("halt_ign1", 1, 32'h0FC, 1, 0, 32'h1FC, 1, 1);
        drv(9'h104, 1, 9'h104, 1, 32'h0FC, 32'hFFFF_FFF8, 1, 0, 0, 0, 32'h0);
        chk("halt_ign2", 1, 32'h0FC, 1, 0, 32'h1FC, 1, 1);
        drv(9'h104, 1, 9'h140, 0, 0, 32'h10, 1, 0, 0, 0, 32'h1);
        chk("halt_ign3", 1, 32'h0FC, 1, 0, 32'h1FC, 1, 1);
        idle(9'h104); chk("halt_no_upd", 1, 32'h0FC, 1, 0, 32'h1FC, 1, 1);
        idle(9'h140); chk("halt_no_alloc", 0, 0, 1, 0, 32'h1FC, 1, 1);

        reset_n = 1'b0;
        idle(9'h140); chk("rst_from_halt", 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        idle(9'h104); chk("rst_clear", 0, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
